watch_set_ctrl: RTL and testbench
=================================

// Module: watch_set_ctrl
// PURPOSE
//  Button-driven time-setting controller for the hh:mm watch, on the 32.768 kHz crystal clock.
//  Debounces two push-buttons and steps through hours, tens-of-minutes and minute-units edits.
//  Drives the cfg_hhxx/cfg_xxmx/cfg_xxxm initial values and a one-cycle load strobe to the counters.
//  Also drives field-select and blink outputs so the display path can flash the field being edited.
// PARAMETERS
//  DEBOUNCE_CYC  328    stable clk_i cycles required before a button level is accepted (~10 ms)
//  BLINK_DIV     8192   clk_i cycles per blink_o half-period (2 Hz blink)
//  TIMEOUT_CYC   983040 idle cycles in a SET state before abort (30 s); used only with WATCH_SET_TIMEOUT_EN
// PORTS
//  clk_i        in   1  32.768 kHz crystal clock
//  rstn_i       in   1  asynchronous reset, active low
//  bt0_i        in   1  MODE button, asynchronous raw level, active high
//  bt1_i        in   1  INC button, asynchronous raw level, active high
//  cur_hhxx_i   in   5  current hours value (0-23), seeds the edit register
//  cur_xxmx_i   in   3  current tens-of-minutes value (0-5)
//  cur_xxxm_i   in   4  current minute units value (0-9)
//  cfg_hhxx_o   out  5  committed hours value
//  cfg_xxmx_o   out  3  committed tens-of-minutes value
//  cfg_xxxm_o   out  4  committed minute units value
//  load_o       out  1  one-cycle commit strobe; cfg_*_o are valid while it is high
//  sel_o        out  2  field being edited: 00 none, 01 hours, 10 tens-of-minutes, 11 minute units
//  blink_o      out  1  blink phase; forced to 0 in RUN
// BEHAVIOUR
//  - Button path per button: 2-FF synchroniser, then a DEBOUNCE_CYC counter.
//    The debounced level changes only after the synchronised level has been stable for DEBOUNCE_CYC cycles.
//    A 0->1 edge of the debounced level gives a single-cycle press pulse (mode_p, inc_p).
//  - FSM states: RUN, SET_HH, SET_MT, SET_MU.
//    RUN --mode_p--> SET_HH: edit regs load cur_*_i in the same cycle.
//    SET_HH --mode_p--> SET_MT --mode_p--> SET_MU --mode_p--> RUN.
//  - inc_p in SET_HH: hh = (hh==23) ? 0 : hh+1.
//    inc_p in SET_MT: mt = (mt==5) ? 0 : mt+1.
//    inc_p in SET_MU: mu = (mu==9) ? 0 : mu+1.
//    inc_p in RUN has no effect.
//  - Commit: on the SET_MU->RUN transition, cfg_*_o take the edit regs.
//    load_o is high for exactly the following clk_i cycle. cfg_*_o then hold until the next commit.
//  - Simultaneous mode_p and inc_p: mode wins and the increment is discarded.
//  - Held button: one press pulse only, no auto-repeat.
//  - sel_o is registered: it follows the state with 1 cycle latency.
//  - blink_o toggles every BLINK_DIV cycles while in any SET state.
//    The blink counter restarts at entry to SET_HH and after every inc_p, so blink_o=1 right after an edit.
//  - Reset values: state RUN, cfg_*_o 0, load_o 0, sel_o 00, blink_o 0, debounced levels 0, edit regs 0.
//  - Reset in a SET state: edits are discarded, no load_o.
//    A button held through reset release gives no press pulse.
//  - cur_*_i values above range (hh>23, mt>5, mu>9) are clamped to 0 on seeding.
//  - load_o is in the clk_i domain. Transfer to divided-clock counters happens at integration and is not part of this block.
// CONFIGURATION
//  WATCH_SET_TIMEOUT_EN defined:
//    An idle counter clears on every press pulse.
//    After TIMEOUT_CYC cycles with no press in any SET state, the FSM returns to RUN.
//    No load_o and no cfg change on timeout (abort).
//  WATCH_SET_TIMEOUT_EN undefined:
//    No idle counter; SET states are held indefinitely.
//    The TIMEOUT_CYC parameter is unused.
// STRUCTURE
//  Shared package/header watch_pkg: FSM state encodings, sel codes, limits HH_MAX=23, MT_MAX=5, MU_MAX=9.
//  Sub-module btn_debounce (synchroniser, debounce counter, rise pulse), instantiated twice.
//  FSM, edit registers, commit, blink and timeout logic stay in watch_set_ctrl.
// TESTING (bench uses DEBOUNCE_CYC=4, BLINK_DIV=8, TIMEOUT_CYC=64)
//  1. cur=13:4:7, press MODE, INC x2, MODE, MODE, MODE
//     -> one load_o pulse; cfg_hhxx=15, cfg_xxmx=4, cfg_xxxm=7.
//  2. bt1 glitches 2 cycles high, 3 times
//     -> no increment. A clean 6-cycle press -> exactly one increment.
//  3. Wrap: hours from 23 +1 -> 0; tens from 5 +1 -> 0; units from 9 +1 -> 0; cfg shows 00:0:0 after commit.
//  4. MODE and INC pulses in the same cycle in SET_HH
//     -> state SET_MT, hours unchanged, sel_o=10 one cycle later.
//  5. rstn_i low while in SET_MT
//     -> all outputs at reset values, no load_o, state RUN after release.
//  6. WATCH_SET_TIMEOUT_EN: enter SET_HH, INC, then idle 64 cycles
//     -> back to RUN, sel_o=00, no load_o, cfg unchanged. Without the macro: still SET_HH after 1000 cycles.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and limits for the watch time-setting controller.
package watch_pkg;

   // FSM encoding; SET states carry the same code as the field they select.
   typedef enum logic [1:0] {
      StRun   = 2'b00,
      StSetHh = 2'b01,
      StSetMt = 2'b10,
      StSetMu = 2'b11
   } state_e;

   localparam logic [1:0] SelNone = 2'b00;
   localparam logic [1:0] SelHh   = 2'b01;
   localparam logic [1:0] SelMt   = 2'b10;
   localparam logic [1:0] SelMu   = 2'b11;

   localparam logic [4:0] HH_MAX = 5'd23;
   localparam logic [2:0] MT_MAX = 3'd5;
   localparam logic [3:0] MU_MAX = 4'd9;

   // Out-of-range seeds from the running counters become 0.
   function automatic logic [4:0] clamp_hh(input logic [4:0] v);
      return (v > HH_MAX) ? 5'd0 : v;
   endfunction

   function automatic logic [2:0] clamp_mt(input logic [2:0] v);
      return (v > MT_MAX) ? 3'd0 : v;
   endfunction

   function automatic logic [3:0] clamp_mu(input logic [3:0] v);
      return (v > MU_MAX) ? 4'd0 : v;
   endfunction

   function automatic logic [4:0] inc_hh(input logic [4:0] v);
      return (v == HH_MAX) ? 5'd0 : v + 5'd1;
   endfunction

   function automatic logic [2:0] inc_mt(input logic [2:0] v);
      return (v == MT_MAX) ? 3'd0 : v + 3'd1;
   endfunction

   function automatic logic [3:0] inc_mu(input logic [3:0] v);
      return (v == MU_MAX) ? 4'd0 : v + 4'd1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, rising-edge press pulse.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 328
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            level_q, level_d;
   logic [1:0]      vld_q, vld_d;
   logic            armed_q, armed_d;
   logic            press_q, press_d;

   // Debounce counter, arming and press-pulse next state.
   always_comb begin
      sync1_d = btn_i;
      sync2_d = sync1_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntLast) begin
         cnt_d   = '0;
         level_d = sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      // vld marks the synchroniser output as meaningful after reset; a press is only
      // reported once the button has been seen released, so a held button gives no pulse.
      vld_d   = {vld_q[0], 1'b1};
      armed_d = armed_q | (vld_q[1] & ~sync2_q & ~level_q);
      press_d = armed_q & level_d & ~level_q;
   end

   // Button state registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         vld_q   <= 2'b00;
         armed_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         vld_q   <= vld_d;
         armed_q <= armed_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/watch_set_ctrl.sv
// Button-driven hh:mm time-setting controller (MODE/INC buttons, commit strobe, blink).
// Optional idle abort from SET states is enabled by defining WATCH_SET_TIMEOUT_EN.
module watch_set_ctrl
   import watch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 328,
   parameter int unsigned BLINK_DIV    = 8192,
   parameter int unsigned TIMEOUT_CYC  = 983040
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       bt0_i,
   input  logic       bt1_i,
   input  logic [4:0] cur_hhxx_i,
   input  logic [2:0] cur_xxmx_i,
   input  logic [3:0] cur_xxxm_i,
   output logic [4:0] cfg_hhxx_o,
   output logic [2:0] cfg_xxmx_o,
   output logic [3:0] cfg_xxxm_o,
   output logic       load_o,
   output logic [1:0] sel_o,
   output logic       blink_o
);

   localparam int unsigned BlinkW = $clog2(BLINK_DIV + 1);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

   if (TIMEOUT_CYC == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be non-zero");
   end

   logic mode_p, inc_p, timeout, inc_hit;

   state_e            state_q, state_d;
   logic [4:0]        hh_q, hh_d;
   logic [2:0]        mt_q, mt_d;
   logic [3:0]        mu_q, mu_d;
   logic [4:0]        cfg_hh_q, cfg_hh_d;
   logic [2:0]        cfg_mt_q, cfg_mt_d;
   logic [3:0]        cfg_mu_q, cfg_mu_d;
   logic              load_q, load_d;
   logic [1:0]        sel_q, sel_d;
   logic              blink_q, blink_d;
   logic [BlinkW-1:0] bcnt_q, bcnt_d;

   btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_btn_mode (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .btn_i  (bt0_i),
      .press_o(mode_p)
   );

   btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_btn_inc (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .btn_i  (bt1_i),
      .press_o(inc_p)
   );

`ifdef WATCH_SET_TIMEOUT_EN
   localparam int unsigned IdleW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYC - 1);

   logic [IdleW-1:0] idle_q, idle_d;

   // Idle counter: cleared by any press or in RUN, saturates at the abort point.
   always_comb begin
      idle_d = idle_q;
      if (state_q == StRun || mode_p || inc_p) begin
         idle_d = '0;
      end else if (idle_q != IdleLast) begin
         idle_d = idle_q + 1'b1;
      end
      timeout = (state_q != StRun) && !mode_p && !inc_p && (idle_q == IdleLast);
   end

   // Idle counter register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // FSM, edit registers and commit; MODE takes priority over INC.
   always_comb begin
      state_d  = state_q;
      hh_d     = hh_q;
      mt_d     = mt_q;
      mu_d     = mu_q;
      cfg_hh_d = cfg_hh_q;
      cfg_mt_d = cfg_mt_q;
      cfg_mu_d = cfg_mu_q;
      load_d   = 1'b0;
      inc_hit  = 1'b0;
      unique case (state_q)
         StRun: begin
            if (mode_p) begin
               state_d = StSetHh;
               hh_d    = clamp_hh(cur_hhxx_i);
               mt_d    = clamp_mt(cur_xxmx_i);
               mu_d    = clamp_mu(cur_xxxm_i);
            end
         end
         StSetHh: begin
            if (mode_p) begin
               state_d = StSetMt;
            end else if (timeout) begin
               state_d = StRun;
            end else if (inc_p) begin
               hh_d    = inc_hh(hh_q);
               inc_hit = 1'b1;
            end
         end
         StSetMt: begin
            if (mode_p) begin
               state_d = StSetMu;
            end else if (timeout) begin
               state_d = StRun;
            end else if (inc_p) begin
               mt_d    = inc_mt(mt_q);
               inc_hit = 1'b1;
            end
         end
         StSetMu: begin
            if (mode_p) begin
               state_d  = StRun;
               cfg_hh_d = hh_q;
               cfg_mt_d = mt_q;
               cfg_mu_d = mu_q;
               load_d   = 1'b1;
            end else if (timeout) begin
               state_d = StRun;
            end else if (inc_p) begin
               mu_d    = inc_mu(mu_q);
               inc_hit = 1'b1;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // Blink phase: off in RUN, restarts high on SET entry and after each edit.
   always_comb begin
      blink_d = blink_q;
      bcnt_d  = bcnt_q;
      if (state_d == StRun) begin
         blink_d = 1'b0;
         bcnt_d  = '0;
      end else if (state_q == StRun || inc_hit) begin
         blink_d = 1'b1;
         bcnt_d  = '0;
      end else if (bcnt_q == BlinkLast) begin
         blink_d = ~blink_q;
         bcnt_d  = '0;
      end else begin
         bcnt_d = bcnt_q + 1'b1;
      end
   end

   // Field select trails the state register by one cycle.
   always_comb begin
      sel_d = SelNone;
      unique case (state_q)
         StRun:   sel_d = SelNone;
         StSetHh: sel_d = SelHh;
         StSetMt: sel_d = SelMt;
         StSetMu: sel_d = SelMu;
         default: sel_d = SelNone;
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= StRun;
         hh_q     <= '0;
         mt_q     <= '0;
         mu_q     <= '0;
         cfg_hh_q <= '0;
         cfg_mt_q <= '0;
         cfg_mu_q <= '0;
         load_q   <= 1'b0;
         sel_q    <= SelNone;
         blink_q  <= 1'b0;
         bcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         hh_q     <= hh_d;
         mt_q     <= mt_d;
         mu_q     <= mu_d;
         cfg_hh_q <= cfg_hh_d;
         cfg_mt_q <= cfg_mt_d;
         cfg_mu_q <= cfg_mu_d;
         load_q   <= load_d;
         sel_q    <= sel_d;
         blink_q  <= blink_d;
         bcnt_q   <= bcnt_d;
      end
   end

   assign cfg_hhxx_o = cfg_hh_q;
   assign cfg_xxmx_o = cfg_mt_q;
   assign cfg_xxxm_o = cfg_mu_q;
   assign load_o     = load_q;
   assign sel_o      = sel_q;
   assign blink_o    = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl with short debounce/blink/timeout parameters.
module tb_watch_set_ctrl;

   logic       clk = 1'b0;
   logic       rstn;
   logic       bt0, bt1;
   logic [4:0] cur_hh;
   logic [2:0] cur_mt;
   logic [3:0] cur_mu;
   logic [4:0] cfg_hh;
   logic [2:0] cfg_mt;
   logic [3:0] cfg_mu;
   logic       load;
   logic [1:0] sel;
   logic       blink;

   int total = 0;
   int bad   = 0;
   int load_cnt = 0;

   watch_set_ctrl #(
      .DEBOUNCE_CYC(4),
      .BLINK_DIV   (8),
      .TIMEOUT_CYC (64)
   ) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .bt0_i     (bt0),
      .bt1_i     (bt1),
      .cur_hhxx_i(cur_hh),
      .cur_xxmx_i(cur_mt),
      .cur_xxxm_i(cur_mu),
      .cfg_hhxx_o(cfg_hh),
      .cfg_xxmx_o(cfg_mt),
      .cfg_xxxm_o(cfg_mu),
      .load_o    (load),
      .sel_o     (sel),
      .blink_o   (blink)
   );

   always #5 clk = ~clk;

   // Count load strobes, sampled away from the active edge.
   always @(negedge clk) begin
      if (load === 1'b1) load_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raise button(s) (0: MODE, 1: INC, 2: both); returns just after the press takes effect.
   task automatic press_start(input int b);
      if (b == 0 || b == 2) bt0 = 1'b1;
      if (b == 1 || b == 2) bt1 = 1'b1;
      wait_n(7);
   endtask

   task automatic press_end();
      bt0 = 1'b0;
      bt1 = 1'b0;
      wait_n(10);
   endtask

   task automatic press(input int b);
      press_start(b);
      press_end();
   endtask

   task automatic set_cur(input logic [4:0] h, input logic [2:0] t, input logic [3:0] u);
      cur_hh = h;
      cur_mt = t;
      cur_mu = u;
   endtask

   task automatic chk_cfg(input string tag, input int h, input int t, input int u);
      chk({tag, "_hh"}, 32'(cfg_hh), h);
      chk({tag, "_mt"}, 32'(cfg_mt), t);
      chk({tag, "_mu"}, 32'(cfg_mu), u);
   endtask

   initial begin
      rstn = 1'b0;
      bt0  = 1'b0;
      bt1  = 1'b0;
      set_cur(5'd0, 3'd0, 4'd0);
      wait_n(3);
      chk_cfg("rst_cfg", 0, 0, 0);
      chk("rst_load", 32'(load), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_blink", 32'(blink), 0);
      rstn = 1'b1;
      wait_n(5);

      // 1: 13:4:7, INC x2 on hours, commit 15:4:7
      set_cur(5'd13, 3'd4, 4'd7);
      press_start(0);
      chk("t1_entry_blink", 32'(blink), 1);
      chk("t1_entry_load", 32'(load), 0);
      wait_n(1);
      chk("t1_sel_hh", 32'(sel), 1);
      wait_n(7);
      chk("t1_blink_toggle", 32'(blink), 0);
      press_end();
      press_start(1);
      chk("t1_inc_blink", 32'(blink), 1);
      press_end();
      press(1);
      press(0);
      chk("t1_sel_mt", 32'(sel), 2);
      press(0);
      chk("t1_sel_mu", 32'(sel), 3);
      press_start(0);
      chk("t1_load_hi", 32'(load), 1);
      chk_cfg("t1_cfg", 15, 4, 7);
      chk("t1_run_blink", 32'(blink), 0);
      wait_n(1);
      chk("t1_load_lo", 32'(load), 0);
      chk("t1_sel_run", 32'(sel), 0);
      press_end();
      chk("t1_load_cnt", 32'(load_cnt), 1);

      // 2a: short INC glitches ignored, clean 6-cycle press counts once
      set_cur(5'd10, 3'd2, 4'd3);
      press(0);
      for (int g = 0; g < 3; g++) begin
         bt1 = 1'b1;
         wait_n(2);
         bt1 = 1'b0;
         wait_n(4);
      end
      bt1 = 1'b1;
      wait_n(6);
      bt1 = 1'b0;
      wait_n(12);
      press(0);
      press(0);
      press_start(0);
      chk_cfg("t2_cfg", 11, 2, 3);
      press_end();

      // 2b: INC held 40 cycles gives one step only
      press(0);
      bt1 = 1'b1;
      wait_n(40);
      bt1 = 1'b0;
      wait_n(12);
      press(0);
      press(0);
      press_start(0);
      chk_cfg("t2_hold_cfg", 11, 2, 3);
      press_end();
      chk("t2_load_cnt", 32'(load_cnt), 3);

      // 3: wrap every field
      set_cur(5'd23, 3'd5, 4'd9);
      press(0);
      press(1);
      press(0);
      press(1);
      press(0);
      press(1);
      press_start(0);
      chk_cfg("t3_wrap_cfg", 0, 0, 0);
      press_end();

      // Out-of-range seeds clamp to 0, then +1 each
      set_cur(5'd30, 3'd6, 4'd12);
      press(0);
      press(1);
      press(0);
      press(1);
      press(0);
      press(1);
      press_start(0);
      chk_cfg("clamp_cfg", 1, 1, 1);
      press_end();

      // 4: MODE and INC together in SET_HH
      set_cur(5'd5, 3'd1, 4'd1);
      press(0);
      press_start(2);
      chk("t4_sel_lag", 32'(sel), 1);
      wait_n(1);
      chk("t4_sel_mt", 32'(sel), 2);
      press_end();
      press(0);
      press_start(0);
      chk_cfg("t4_cfg", 5, 1, 1);
      press_end();
      chk("t4_load_cnt", 32'(load_cnt), 6);

      // 5: reset while in SET_MT
      set_cur(5'd7, 3'd3, 4'd2);
      press(0);
      press(0);
      wait_n(3);
      rstn = 1'b0;
      #1;
      chk_cfg("t5_rst_cfg", 0, 0, 0);
      chk("t5_rst_load", 32'(load), 0);
      chk("t5_rst_sel", 32'(sel), 0);
      chk("t5_rst_blink", 32'(blink), 0);
      wait_n(2);
      rstn = 1'b1;
      wait_n(20);
      chk("t5_sel_run", 32'(sel), 0);
      chk("t5_load_cnt", 32'(load_cnt), 6);
      // MODE held through reset release: no press
      bt0 = 1'b1;
      wait_n(3);
      rstn = 1'b0;
      wait_n(3);
      rstn = 1'b1;
      wait_n(30);
      chk("t5_held_sel", 32'(sel), 0);
      bt0 = 1'b0;
      wait_n(12);
      press(0);
      chk("t5_press_after", 32'(sel), 1);

      // 6: idle in SET_HH after an INC
      press(1);
      wait_n(40);
      chk("t6_sel_early", 32'(sel), 1);
`ifdef WATCH_SET_TIMEOUT_EN
      wait_n(60);
      chk("t6_sel_abort", 32'(sel), 0);
      chk("t6_blink_abort", 32'(blink), 0);
      chk("t6_load_cnt", 32'(load_cnt), 6);
      chk_cfg("t6_cfg", 0, 0, 0);
`else
      wait_n(1000);
      chk("t6_sel_hold", 32'(sel), 1);
      chk("t6_load_cnt", 32'(load_cnt), 6);
      chk_cfg("t6_cfg", 0, 0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
